btb_next_pc: RTL and testbench



---
 rtl/btb_next_pc_pkg.sv | 22 ++
 rtl/btb_next_pc_sat_ctr2.sv | 21 ++
 rtl/btb_next_pc.sv | 139 +++++++++++++
 tb/tb_btb_next_pc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_next_pc_pkg.sv
// Shared types and constants for the next-PC / branch target buffer unit.
package btb_next_pc_pkg;

  // Major opcodes of the control-transfer instructions that feed ex_update.
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // 2-bit direction counter encodings; MSB set means "predict taken".
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Direction state of one BTB entry. Tag and target widths depend on the
  // instantiating module's PC_W/ENTRIES, so those live in parallel arrays.
  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
  } btb_entry_t;

endpackage

// File: rtl/btb_next_pc_sat_ctr2.sv
// 2-bit saturating direction counter update: count up on taken, down on
// not-taken, clamped to SNT..ST.
module sat_ctr2
  import btb_next_pc_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  // Saturating step in the resolved direction.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/btb_next_pc.sv
// Fetch PC register plus direct-mapped BTB with 2-bit direction counters.
// Predicts in IF, trains from EX, redirects on misprediction, and counts
// resolved control instructions and mispredictions.
//
// Handshake: ex_update is a valid-only strobe. There is no ready; every
// cycle with ex_update=1 is consumed at that clock edge (training and
// counting), unless RST is high in the same cycle, in which case it is
// dropped.
module btb_next_pc
  import btb_next_pc_pkg::*;
#(
  parameter int unsigned     PC_W     = 12,
  parameter int unsigned     ENTRIES  = 16,
  parameter int unsigned     CNT_W    = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             stall,
  output logic [PC_W-1:0]  pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             ex_update,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] ctrl_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  // BTB storage
  btb_entry_t       dir_q [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [PC_W-1:0]  tgt_q [ENTRIES];

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0] mis_q, mis_d;

  // Lookup side (fetch PC)
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  // Update side (EX PC)
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       up_ctr_next;

  assign lk_idx = pc_q[IDX_W+1:2];
  assign lk_tag = pc_q[PC_W-1:IDX_W+2];
  assign up_idx = ex_pc[IDX_W+1:2];
  assign up_tag = ex_pc[PC_W-1:IDX_W+2];

  // Combinational lookup against the pre-edge array contents.
  always_comb begin
    lk_hit      = dir_q[lk_idx].valid && (tag_q[lk_idx] == lk_tag);
    pred_taken  = lk_hit && dir_q[lk_idx].ctr[1];
    pred_target = lk_hit ? tgt_q[lk_idx] : '0;
    up_hit      = dir_q[up_idx].valid && (tag_q[up_idx] == up_tag);
  end

  // Redirect when direction or taken target disagrees with the prediction.
  assign mispredict = ex_update &&
                      ((ex_pred_taken != ex_taken) ||
                       (ex_taken && (ex_pred_target != ex_target)));

  sat_ctr2 u_sat_ctr2 (
    .ctr_i   (dir_q[up_idx].ctr),
    .taken_i (ex_taken),
    .ctr_o   (up_ctr_next)
  );

  // Next fetch PC: redirect beats stall, stall beats prediction.
  always_comb begin
    pc_d = pc_q + PC_W'(4);
    if (mispredict) begin
      pc_d = ex_taken ? ex_target : (ex_pc + PC_W'(4));
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  // Saturating performance counter next values.
  always_comb begin
    ctrl_d = ctrl_q;
    mis_d  = mis_q;
    if (ex_update && (ctrl_q != '1)) ctrl_d = ctrl_q + CNT_W'(1);
    if (mispredict && (mis_q != '1)) mis_d = mis_q + CNT_W'(1);
  end

  // PC and counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q   <= RESET_PC;
      ctrl_q <= '0;
      mis_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      ctrl_q <= ctrl_d;
      mis_q  <= mis_d;
    end
  end

  // BTB training from the resolving instruction; independent of stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        dir_q[i] <= '{valid: 1'b0, ctr: WNT};
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (ex_update) begin
      if (up_hit) begin
        dir_q[up_idx].ctr <= up_ctr_next;
        if (ex_taken) tgt_q[up_idx] <= ex_target;
      end else if (ex_taken) begin
        // Allocation evicts whatever alias occupied this index.
        dir_q[up_idx] <= '{valid: 1'b1, ctr: WT};
        tag_q[up_idx] <= up_tag;
        tgt_q[up_idx] <= ex_target;
      end
    end
  end

  assign pc            = pc_q;
  assign ctrl_count    = ctrl_q;
  assign mispred_count = mis_q;

endmodule

// File: tb/tb_btb_next_pc.sv
// Bench for btb_next_pc: directed scenarios then random traffic, checked
// against an array-based reference model of the BTB and fetch PC.
module tb_btb_next_pc;

  localparam int PCW  = 12;
  localparam int ENT  = 16;
  localparam int IDXW = 4;
  localparam int unsigned PC_MOD = 4096;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            RST = 1'b1;
  logic            stall = 1'b0;
  logic            ex_update = 1'b0;
  logic [PCW-1:0]  ex_pc = '0;
  logic            ex_taken = 1'b0;
  logic [PCW-1:0]  ex_target = '0;
  logic            ex_pred_taken = 1'b0;
  logic [PCW-1:0]  ex_pred_target = '0;

  logic [PCW-1:0]  pc, pred_target, pc4, pred_target4;
  logic            pred_taken, mispredict, pred_taken4, mispredict4;
  logic [15:0]     ctrl_count, mispred_count;
  logic [3:0]      ctrl_count4, mispred_count4;

  btb_next_pc #(.PC_W(12), .ENTRIES(16), .CNT_W(16), .RESET_PC(12'h000)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_update(ex_update), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .mispredict(mispredict),
    .ctrl_count(ctrl_count), .mispred_count(mispred_count)
  );

  btb_next_pc #(.PC_W(12), .ENTRIES(16), .CNT_W(4), .RESET_PC(12'h000)) dut_c4 (
    .CLK(CLK), .RST(RST), .stall(stall), .pc(pc4),
    .pred_taken(pred_taken4), .pred_target(pred_target4),
    .ex_update(ex_update), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .mispredict(mispredict4),
    .ctrl_count(ctrl_count4), .mispred_count(mispred_count4)
  );

  // ---------------- reference model ----------------
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [PCW-1:0] exp_q[$];

  int unsigned m_pc;
  bit          m_v   [ENT];
  int unsigned m_tag [ENT];
  int unsigned m_tgt [ENT];
  int          m_ctr [ENT];
  int unsigned m_ctrl, m_mis, m_ctrl4, m_mis4;

  function automatic int unsigned m_idx(int unsigned a);
    return (a >> 2) % ENT;
  endfunction

  function automatic int unsigned m_tagf(int unsigned a);
    return a >> (IDXW + 2);
  endfunction

  function automatic bit m_hit(int unsigned a);
    return m_v[m_idx(a)] && (m_tag[m_idx(a)] == m_tagf(a));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_v[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_pc = 0; m_ctrl = 0; m_mis = 0; m_ctrl4 = 0; m_mis4 = 0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive, check combinational outputs against the model,
  // advance the model, clock, then check the registered PC.
  task automatic cyc(bit rst, bit stl, bit upd, int unsigned epc, bit etk,
                     int unsigned etg, bit eptk, int unsigned eptg);
    int unsigned i, ui, nxt, ptg;
    bit hit, ptk, mis;
    RST = rst; stall = stl; ex_update = upd;
    ex_pc = PCW'(epc); ex_taken = etk; ex_target = PCW'(etg);
    ex_pred_taken = eptk; ex_pred_target = PCW'(eptg);
    #1;
    i   = m_idx(m_pc);
    hit = m_hit(m_pc);
    ptk = hit && (m_ctr[i] >= 2);
    ptg = hit ? m_tgt[i] : 0;
    mis = upd && ((eptk != etk) || (etk && (eptg != etg)));
    chk("pred_taken", 32'(pred_taken), 32'(ptk));
    chk("pred_target", 32'(pred_target), ptg);
    chk("mispredict", 32'(mispredict), 32'(mis));
    chk("ctrl_count", 32'(ctrl_count), m_ctrl);
    chk("mispred_count", 32'(mispred_count), m_mis);
    chk("c4_pred_taken", 32'(pred_taken4), 32'(ptk));
    chk("c4_mispredict", 32'(mispredict4), 32'(mis));
    chk("c4_ctrl_count", 32'(ctrl_count4), m_ctrl4);
    chk("c4_mispred_count", 32'(mispred_count4), m_mis4);
    if (mis)       nxt = etk ? etg : (epc + 4) % PC_MOD;
    else if (stl)  nxt = m_pc;
    else if (ptk)  nxt = ptg;
    else           nxt = (m_pc + 4) % PC_MOD;
    if (rst) begin
      model_reset();
      nxt = 0;
    end else begin
      if (upd) begin
        if (m_ctrl < 65535) m_ctrl++;
        if (m_ctrl4 < 15) m_ctrl4++;
        ui = m_idx(epc);
        if (m_hit(epc)) begin
          if (etk) begin
            if (m_ctr[ui] < 3) m_ctr[ui]++;
            m_tgt[ui] = etg;
          end else if (m_ctr[ui] > 0) m_ctr[ui]--;
        end else if (etk) begin
          m_v[ui] = 1'b1; m_tag[ui] = m_tagf(epc); m_tgt[ui] = etg; m_ctr[ui] = 2;
        end
      end
      if (mis) begin
        if (m_mis < 65535) m_mis++;
        if (m_mis4 < 15) m_mis4++;
      end
    end
    m_pc = nxt;
    exp_q.push_back(PCW'(nxt));
    @(posedge CLK); #1;
    begin
      logic [PCW-1:0] e;
      e = exp_q.pop_front();
      chk("pc_next", 32'(pc), 32'(e));
      chk("c4_pc_next", 32'(pc4), 32'(e));
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Redirect fetch to a: not-taken mispredict of a miss at a-4.
  task automatic goto_pc(int unsigned a);
    cyc(0, 0, 1, (a + PC_MOD - 4) % PC_MOD, 0, 0, 1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int unsigned epc, etg, eptg;
    bit etk, eptk, upd, stl, rst;

    RST = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    model_reset();

    // Reset values and sequential fetch
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_pred_target", 32'(pred_target), 32'd0);
    chk("rst_ctrl", 32'(ctrl_count), 32'd0);
    chk("rst_mispred", 32'(mispred_count), 32'd0);
    idle(); chk("seq_pc4", 32'(pc), 32'h004);
    idle(); chk("seq_pc8", 32'(pc), 32'h008);

    // Taken branch at 0x010 allocates and redirects
    cyc(0, 0, 1, 'h010, 1, 'h040, 0, 0);
    chk("alloc_redirect_pc", 32'(pc), 32'h040);
    chk("alloc_mispred_cnt", 32'(mispred_count), 32'd1);
    goto_pc('h010);
    chk("hit_pred_taken", 32'(pred_taken), 32'd1);
    chk("hit_pred_target", 32'(pred_target), 32'h040);
    idle(); chk("hit_follow_pc", 32'(pc), 32'h040);

    // Two not-taken resolutions train the counter down to 0
    cyc(0, 0, 1, 'h010, 0, 0, 1, 'h040);
    chk("nt1_recover_pc", 32'(pc), 32'h014);
    cyc(0, 0, 1, 'h010, 0, 0, 1, 'h040);
    chk("nt2_recover_pc", 32'(pc), 32'h014);
    goto_pc('h010);
    chk("nt_pred_taken", 32'(pred_taken), 32'd0);

    // Redirect beats stall; stall alone holds
    cyc(0, 1, 1, 'h100, 1, 'h200, 0, 0);
    chk("stall_redirect_pc", 32'(pc), 32'h200);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      chk("stall_hold_pc", 32'(pc), 32'h200);
    end
    idle(); chk("stall_release_pc", 32'(pc), 32'h204);

    // Wraparound of pc+4 and ex_pc+4
    goto_pc('hFFC);
    idle(); chk("wrap_pc", 32'(pc), 32'h000);
    cyc(0, 0, 1, 'hFFC, 0, 0, 1, 'h123);
    chk("wrap_ex_pc", 32'(pc), 32'h000);

    // Aliasing: 0x050 shares index 4 with 0x010
    cyc(0, 0, 1, 'h050, 1, 'h080, 0, 0);
    goto_pc('h010);
    chk("alias_evicted_taken", 32'(pred_taken), 32'd0);
    chk("alias_evicted_target", 32'(pred_target), 32'd0);
    goto_pc('h050);
    chk("alias_new_taken", 32'(pred_taken), 32'd1);
    chk("alias_new_target", 32'(pred_target), 32'h080);

    // Mid-stream reset with a concurrent update
    cyc(1, 0, 1, 'h010, 1, 'h300, 0, 0);
    chk("mid_rst_pc", 32'(pc), 32'h000);
    chk("mid_rst_ctrl", 32'(ctrl_count), 32'd0);
    chk("mid_rst_mispred", 32'(mispred_count), 32'd0);
    goto_pc('h050);
    chk("mid_rst_invalid", 32'(pred_taken), 32'd0);

    // Counter saturation on the CNT_W=4 instance
    for (int k = 0; k < 20; k++) goto_pc('h100);
    chk("sat_c4_mispred", 32'(mispred_count4), 32'd15);
    chk("sat_c4_ctrl", 32'(ctrl_count4), 32'd15);
    chk("sat_c16_mispred", 32'(mispred_count), 32'd21);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      stl  = ($urandom_range(0, 3) == 0);
      upd  = ($urandom_range(0, 1) == 1);
      epc  = $urandom_range(0, 63) << 2;
      etk  = ($urandom_range(0, 1) == 1);
      etg  = $urandom_range(0, 1023) << 2;
      if ($urandom_range(0, 1) == 1) begin
        eptk = m_hit(epc) && (m_ctr[m_idx(epc)] >= 2);
        eptg = m_hit(epc) ? m_tgt[m_idx(epc)] : 0;
      end else begin
        eptk = ($urandom_range(0, 1) == 1);
        eptg = ($urandom_range(0, 1) == 1) ? etg : ($urandom_range(0, 1023) << 2);
      end
      cyc(rst, stl, upd, epc, etk, etg, eptk, eptg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin : watchdog
    #200000;
    n_err++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
